// File: rtl/start_pulse_gen.sv
// Arms a programmable delay and emits a single-cycle start pulse when it expires.
// A pending start can be cancelled with abort; oversized delays are clamped and flagged.
module start_pulse_gen #(
    parameter int MAX_WAIT = 20,
    parameter int DLY_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic [DLY_W-1:0] delay,
    input  logic             abort,
    output logic             start,
    output logic             busy,
    output logic             err,
    output logic             aborted
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Largest loadable count; delay > MAX_M1 is the same test as delay >= MAX_WAIT.
    localparam logic [DLY_W-1:0] MAX_M1 = DLY_W'(MAX_WAIT - 1);

    function automatic logic [DLY_W-1:0] clamp_delay(input logic [DLY_W-1:0] d);
        return (d > MAX_M1) ? MAX_M1 : d;
    endfunction

    function automatic logic delay_too_long(input logic [DLY_W-1:0] d);
        return (d > MAX_M1);
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DLY_W-1:0] r_cnt;
    logic [DLY_W-1:0] w_cnt_nxt;
    logic             r_start;
    logic             w_start_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_aborted;
    logic             w_aborted_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_start   <= w_start_nxt;
            r_busy    <= w_busy_nxt;
            r_err     <= w_err_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

    // Flags default low so each one lasts exactly one cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_start_nxt   = 1'b0;
        w_busy_nxt    = r_busy;
        w_err_nxt     = 1'b0;
        w_aborted_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (arm && !abort) begin
                    w_state_nxt = COUNT;
                    w_cnt_nxt   = clamp_delay(delay);
                    w_busy_nxt  = 1'b1;
                    w_err_nxt   = delay_too_long(delay);
                end
            end
            COUNT: begin
                // abort takes priority even on the terminal count
                if (abort) begin
                    w_state_nxt   = IDLE;
                    w_busy_nxt    = 1'b0;
                    w_aborted_nxt = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_start_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign start   = r_start;
    assign busy    = r_busy;
    assign err     = r_err;
    assign aborted = r_aborted;

endmodule

// File: doc/start_pulse_gen.md
START_PULSE_GEN -- requirements
Module: start_pulse_gen

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 20, meaning the maximum number of clk cycles from an accepted arm to the start pulse.
REQ-002 SHALL have parameter DLY_W, default 5, meaning the width of the delay input; MAX_WAIT-1 SHALL fit in DLY_W bits.
REQ-003 SHALL have port clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port arm  input  1  request to schedule one start pulse.
REQ-006 SHALL have port delay  input  DLY_W  requested wait in cycles, sampled with arm.
REQ-007 SHALL have port abort  input  1  cancel a pending start.
REQ-008 SHALL have port start  output  1  single-cycle start pulse.
REQ-009 SHALL have port busy  output  1  a start is pending.
REQ-010 SHALL have port err  output  1  single-cycle flag: requested delay was clamped.
REQ-011 SHALL have port aborted  output  1  single-cycle flag: a pending start was cancelled.

Function
REQ-012 SHALL implement states IDLE and COUNT, plus a DLY_W-bit down-counter cnt.
REQ-013 All outputs SHALL be registered.
REQ-014 In IDLE, an edge with arm=1 and abort=0 SHALL be accepted: cnt <= D_eff, state <= COUNT, busy <= 1.
REQ-015 D_eff SHALL be delay when delay < MAX_WAIT, and MAX_WAIT-1 otherwise.
REQ-016 On the accepting edge, err SHALL be 1 exactly when delay >= MAX_WAIT; otherwise err SHALL be 0.
REQ-017 In IDLE, arm=1 together with abort=1 SHALL be ignored: no state change, no flags.
REQ-018 In COUNT with abort=0 and cnt != 0, cnt SHALL decrement by 1 per edge.
REQ-019 In COUNT with abort=0 and cnt == 0, the edge SHALL set start <= 1, busy <= 0, state <= IDLE.
REQ-020 Latency: arm accepted at edge k SHALL give start high for exactly one cycle, from edge k+1+D_eff to edge k+2+D_eff.
REQ-021 The start pulse SHALL therefore always occur within MAX_WAIT edges of acceptance.
REQ-022 In COUNT with abort=1, the edge SHALL set aborted <= 1, busy <= 0, state <= IDLE, and no start for that request.
REQ-023 When abort=1 and cnt == 0 on the same COUNT edge, abort SHALL win: aborted=1, start=0.
REQ-024 arm SHALL be ignored while in COUNT; requests are not queued.
REQ-025 arm sampled in IDLE on the edge where start is high SHALL be accepted, allowing back-to-back requests.
REQ-026 start, err and aborted SHALL each be high for at most one cycle per request; start and aborted SHALL never be high together.

Reset
REQ-027 On an edge with rst_n=0, the block SHALL set state <= IDLE, cnt <= 0, and start, busy, err, aborted <= 0, overriding all other inputs.
REQ-028 Reset asserted while in COUNT SHALL discard the pending request with no start and no aborted pulse.
REQ-029 After rst_n returns high, the first edge SHALL be able to accept arm.

Verification
REQ-030 arm=1, delay=3 at edge 10 -> busy=1 after edge 10; start=1 only between edges 14 and 15; busy=0 after edge 14; err=0.
REQ-031 arm=1, delay=0 at edge 5 -> start=1 between edges 6 and 7; err=0.
REQ-032 arm=1, delay=25, MAX_WAIT=20 at edge 0 -> err=1 for one cycle after edge 0; start=1 between edges 20 and 21.
REQ-033 arm=1, delay=5 at edge 0; abort=1 at edge 3 -> aborted=1 between edges 3 and 4; busy=0 after edge 3; start stays 0 through edge 30.
REQ-034 arm=1, delay=2 at edge 0; abort=1 at edge 3 (cnt==0) -> aborted=1, start=0; then arm=1, delay=1 at edge 4 -> start between edges 6 and 7.
REQ-035 arm=1, delay=4 at edge 0; rst_n=0 at edge 2 -> all outputs 0 after edge 2; no start through edge 30; second arm at edge 8 honoured.
